// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the processor load/store port (C) and a DMA/debug
// port (D): per-cycle round-robin, lockable bounded D bursts, registered D read data.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {ST_ARB = 1'b0, ST_BURST = 1'b1} state_t;

  localparam logic [7:0] MAX_CNT = MAX_BURST[7:0];

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic [7:0]            r_burst_cnt;
  logic [7:0]            w_cnt_nxt;
  logic                  r_dma_rvalid;
  logic [DATA_WIDTH-1:0] r_dma_rdata;
  logic                  w_cpu_gnt;
  logic                  w_dma_gnt;
  logic                  w_burst_hold;

  // Grant decision: a locked burst overrides round-robin until the waiting processor's budget runs out
  always_comb begin
    w_cpu_gnt    = 1'b0;
    w_dma_gnt    = 1'b0;
    w_burst_hold = (r_state == ST_BURST) && dma_req && dma_lock;
    if (w_burst_hold && (r_burst_cnt < MAX_CNT)) begin
      w_dma_gnt = 1'b1;
    end else if (w_burst_hold && cpu_req) begin
      w_cpu_gnt = 1'b1;
    end else if (cpu_req && dma_req) begin
      if (r_last) begin
        w_cpu_gnt = 1'b1;
      end else begin
        w_dma_gnt = 1'b1;
      end
    end else if (cpu_req) begin
      w_cpu_gnt = 1'b1;
    end else if (dma_req) begin
      w_dma_gnt = 1'b1;
    end else begin
      w_cpu_gnt = 1'b0;
    end
  end

  // Next state and burst counter; only grants taken while the processor waits count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_burst_cnt;
    case (r_state)
      ST_ARB: begin
        if (w_dma_gnt && dma_lock) begin
          w_state_nxt = ST_BURST;
          w_cnt_nxt   = cpu_req ? 8'd1 : 8'd0;
        end else begin
          w_state_nxt = ST_ARB;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_BURST: begin
        if (!dma_lock || !dma_req || w_cpu_gnt) begin
          w_state_nxt = ST_ARB;
          w_cnt_nxt   = 8'd0;
        end else if (w_dma_gnt && cpu_req && (r_burst_cnt < MAX_CNT)) begin
          w_cnt_nxt = r_burst_cnt + 8'd1;
        end else begin
          w_cnt_nxt = r_burst_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Arbitration state, round-robin pointer and burst counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ARB;
      r_last      <= 1'b1;
      r_burst_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_cnt_nxt;
      if (w_cpu_gnt) begin
        r_last <= 1'b0;
      end else if (w_dma_gnt) begin
        r_last <= 1'b1;
      end else begin
        r_last <= r_last;
      end
    end
  end

  // Capture DMA read data from the memory on the edge that completes the granted read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= {DATA_WIDTH{1'b0}};
    end else if (w_dma_gnt && !dma_we) begin
      r_dma_rvalid <= 1'b1;
      r_dma_rdata  <= mem_rdata;
    end else begin
      r_dma_rvalid <= 1'b0;
    end
  end

  // Memory mux: only the granted port reaches the memory, idle drives zeros
  always_comb begin
    mem_addr  = {ADDR_WIDTH{1'b0}};
    mem_wdata = {DATA_WIDTH{1'b0}};
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
    end else if (w_dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
      mem_re    = ~dma_we;
    end else begin
      mem_we    = 1'b0;
    end
  end

  assign cpu_rdata  = w_cpu_gnt ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign cpu_stall  = cpu_req & ~w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign dma_rvalid = r_dma_rvalid;
  assign dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (MAX_BURST=4): per-cycle expected outputs are
// queued as stimulus is applied and popped when the DUT outputs are sampled.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_lock, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  typedef struct packed {
    logic [3:0]  f;     // {cpu_stall, dma_gnt, mem_we, mem_re}
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] crd;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  vec_t        exp_q[$];
  vec_t        e;
  logic        sb_rv;
  logic [31:0] sb_rd;
  int          checks;
  int          errors;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t obs();
    return {cpu_stall, dma_gnt, mem_we, mem_re, mem_addr, mem_wdata, cpu_rdata, dma_rvalid, dma_rdata};
  endfunction

  task automatic set_c(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic set_d(input logic req, input logic lk, input logic we, input logic [31:0] a, input logic [31:0] wd);
    dma_req = req; dma_lock = lk; dma_we = we; dma_addr = a; dma_wdata = wd;
  endtask

  // Push one cycle of expected outputs; a granted DMA read schedules the next cycle's rvalid/rdata
  task automatic expect_cycle(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] crd, input logic d_read, input logic [31:0] rdv);
    exp_q.push_back({f, a, wd, crd, sb_rv, sb_rd});
    sb_rv = d_read;
    if (d_read) sb_rd = rdv;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata = 32'h0000_0099;
    sb_rv = 1'b0; sb_rd = 32'h0;
    for (int i = 0; i < 2; i++) begin
      expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      #3;
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset c%0d got %h want %h", i, obs(), e); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_release got %h want %h", obs(), e); end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_access();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          set_c(1'b1, 1'b0, 32'h10, 32'h0); mem_rdata = 32'h0000_CAFE;
          expect_cycle(4'b0001, 32'h10, 32'h0, 32'h0000_CAFE, 1'b0, 32'h0);
        end
        1: begin
          set_c(1'b1, 1'b1, 32'h14, 32'h0000_BEEF);
          expect_cycle(4'b0010, 32'h14, 32'h0000_BEEF, 32'h0000_CAFE, 1'b0, 32'h0);
        end
        default: begin
          set_c(1'b0, 1'b0, 32'h0, 32'h0);
          expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL cpu_access c%0d got %h want %h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dma_read();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        set_d(1'b1, 1'b0, 1'b0, 32'h40, 32'h0); mem_rdata = 32'h0000_1234;
        expect_cycle(4'b0101, 32'h40, 32'h0, 32'h0, 1'b1, 32'h0000_1234);
      end else begin
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); mem_rdata = 32'h0;
        expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL dma_read c%0d got %h want %h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        set_c(1'b1, 1'b0, 32'h100, 32'h11);
        set_d(1'b1, 1'b0, 1'b1, 32'h200, 32'hD0D0);
        if (i % 2 == 0) expect_cycle(4'b0001, 32'h100, 32'h11, 32'h5555_AAAA, 1'b0, 32'h0);
        else            expect_cycle(4'b1110, 32'h200, 32'hD0D0, 32'h0, 1'b0, 32'h0);
      end else begin
        set_c(1'b0, 1'b0, 32'h0, 32'h0);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL round_robin c%0d got %h want %h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst();
    logic [5:0] stall_pat;
    stall_pat = 6'b111101;
    mem_rdata = 32'h0000_0077;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        set_c(1'b1, 1'b0, 32'h100, 32'h0);
        expect_cycle(4'b0001, 32'h100, 32'h0, 32'h77, 1'b0, 32'h0);
      end else if (i < 7) begin
        set_c(1'b1, 1'b0, 32'h100, 32'h0);
        set_d(1'b1, 1'b1, 1'b1, 32'h200, 32'h5A);
        if (stall_pat[6-i]) expect_cycle(4'b1110, 32'h200, 32'h5A, 32'h0, 1'b0, 32'h0);
        else                expect_cycle(4'b0001, 32'h100, 32'h0, 32'h77, 1'b0, 32'h0);
      end else begin
        set_c(1'b0, 1'b0, 32'h0, 32'h0);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL burst c%0d got %h want %h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_unbounded_burst();
    mem_rdata = 32'h0000_0042;
    for (int i = 0; i < 26; i++) begin
      if (i < 25) set_d(1'b1, 1'b1, 1'b1, 32'h200, 32'h5A);
      else        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (i < 20 || i == 25) set_c(1'b0, 1'b0, 32'h0, 32'h0);
      else                   set_c(1'b1, 1'b0, 32'h180, 32'h0);
      if (i < 20)      expect_cycle(4'b0110, 32'h200, 32'h5A, 32'h0, 1'b0, 32'h0);
      else if (i < 24) expect_cycle(4'b1110, 32'h200, 32'h5A, 32'h0, 1'b0, 32'h0);
      else if (i == 24) expect_cycle(4'b0001, 32'h180, 32'h0, 32'h42, 1'b0, 32'h0);
      else             expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL unbounded c%0d got %h want %h", i, obs(), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midburst();
    // Cycle A: locked DMA write wins the tie (last was C) and opens a burst
    set_c(1'b1, 1'b0, 32'h100, 32'h0);
    set_d(1'b1, 1'b1, 1'b1, 32'h300, 32'hAB);
    mem_rdata = 32'h0000_7777;
    expect_cycle(4'b1110, 32'h300, 32'hAB, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL midburst_a got %h want %h", obs(), e); end
    @(posedge clk); #1;
    // Cycle B: burst DMA read granted, then reset lands before its capture edge
    dma_we = 1'b0;
    expect_cycle(4'b1101, 32'h300, 32'hAB, 32'h0, 1'b0, 32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL midburst_b got %h want %h", obs(), e); end
    reset = 1'b0;
    sb_rv = 1'b0; sb_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) expect_cycle(4'b0001, 32'h100, 32'h0, 32'h7777, 1'b0, 32'h0);
      else       expect_cycle(4'b0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      if (i == 0) #1;
      else @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL midburst_rst c%0d got %h want %h", i, obs(), e); end
      @(posedge clk); #1;
      if (i == 1) reset = 1'b1;
      if (i == 2) begin
        set_c(1'b0, 1'b0, 32'h0, 32'h0);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cpu_access();
    test_dma_read();
    test_round_robin();
    test_burst();
    test_unbounded_burst();
    test_reset_midburst();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
